// File: rtl/r_result_serializer_pkg.sv
// Shared widths and state encoding for the r512 result serializer.
// DATA_WIDTH/MAX_DATA mirror the core-wide defines; WORD_COUNT is derived.
package r_result_serializer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_DATA   = 512;
  localparam int WORD_COUNT = MAX_DATA / DATA_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/r_result_serializer.sv
// Streams one captured r512 result out as LSW-first words (valid/ready).
// Ports: clk, rst, done, result, out_ready -> m, m_valid, m_last, busy, overrun.
module r_result_serializer
  import r_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = r_result_serializer_pkg::DATA_WIDTH,
  parameter int MAX_DATA   = r_result_serializer_pkg::MAX_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [MAX_DATA-1:0]   result,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] m,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int WORDS = MAX_DATA / DATA_WIDTH;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  ser_state_t    state, state_n;
  logic [MAX_DATA-1:0] shift, shift_n;
  logic [MAX_DATA-1:0] pend, pend_n;
  logic          pend_v, pend_v_n;
  logic [IW-1:0] idx, idx_n;
  logic          ovr, ovr_n;
  logic          xfer, last_xfer;

  assign m_valid   = (state == SEND);
  assign m         = m_valid ? shift[DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid && (idx == LAST_IDX);
  assign busy      = m_valid || pend_v;
  assign overrun   = ovr;
  assign xfer      = m_valid && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shift  <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      idx    <= '0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      pend   <= pend_n;
      pend_v <= pend_v_n;
      idx    <= idx_n;
      ovr    <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    pend_n   = pend;
    pend_v_n = pend_v;
    idx_n    = idx;
    ovr_n    = ovr;
    unique case (state)
      IDLE: begin
        if (done) begin
          shift_n = result;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          // Chain the next result with no idle cycle in between.
          if (pend_v) begin
            shift_n  = pend;
            idx_n    = '0;
            pend_v_n = done;
            if (done) pend_n = result;
          end else if (done) begin
            shift_n = result;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_n = shift >> DATA_WIDTH;
            idx_n   = idx + IW'(1);
          end
          if (done) begin
            if (!pend_v) begin
              pend_n   = result;
              pend_v_n = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/r_result_serializer.md
Name: r_result_serializer

Overview:
- Downstream stage of the r512 decryption core.
- Captures one MAX_DATA-bit result when the core pulses done, then streams it out as MAX_DATA/DATA_WIDTH words over a valid/ready handshake.
- Order is least-significant word first. This mirrors the word order of the top-level input shift-in.
- Holds one pending result while busy and flags overrun when a further result arrives with nowhere to go.

Parameters:
- DATA_WIDTH, 32, output word width (same value as the shared define).
- MAX_DATA, 512, result width (same value as the shared define). Must be an integer multiple of DATA_WIDTH.
- WORDS, MAX_DATA/DATA_WIDTH (16), derived localparam: words per result.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- done  input  1  single-cycle pulse from r512: result is valid this cycle.
- result  input  MAX_DATA  core output. Sampled only when done=1.
- out_ready  input  1  consumer accepts the word this cycle.
- m  output  DATA_WIDTH  current output word.
- m_valid  output  1  m holds a valid word.
- m_last  output  1  m is word WORDS-1 of the current result.
- busy  output  1  a result is being streamed or one is pending.
- overrun  output  1  sticky flag: a result was dropped.

Behaviour:
- Reset (async, immediate): m=0, m_valid=0, m_last=0, busy=0, overrun=0. Word index=0, pending buffer empty, state=IDLE. Any transfer in flight is abandoned.
- States:
  - IDLE: m_valid=0, m=0.
  - SEND: m_valid=1, m = shift[DATA_WIDTH-1:0].
- Transfer: occurs on a rising edge where m_valid && out_ready.
- Each transfer in SEND:
  - shift right by DATA_WIDTH;
  - index+1;
  - m_last=1 exactly when index==WORDS-1.
- Backpressure: while m_valid && !out_ready, m, m_last and index hold stable.
- IDLE + done: load result into the shift register, index=0, go to SEND. First word appears on m with m_valid=1 in the next cycle (latency 1).
- SEND + done, pending empty: capture result into pending.
- SEND + done, pending full, no last-transfer this cycle: drop the new result and set overrun=1. Pending and the current stream are unaffected.
- Last transfer (index==WORDS-1), pending full:
  - move pending into the shift register, index=0, stay in SEND (no idle cycle);
  - if done is also high this cycle, the new result enters pending and no overrun occurs.
- Last transfer, pending empty:
  - done high the same cycle: load the new result directly, stay in SEND with no gap;
  - otherwise: go to IDLE.
- busy = (state==SEND) || pending full.
- overrun is cleared only by rst.
- done pulses wider than one cycle are treated as one capture per high cycle. This is illegal upstream and is not guarded.
- Index counter width is clog2(WORDS). It never wraps past WORDS-1; it resets to 0 on each load.

Decomposition:
- parameter.v keeps DATA_WIDTH and MAX_DATA, and gains a WORD_COUNT define (MAX_DATA/DATA_WIDTH) used by this block and the input shift-in.
- State encoding (IDLE=0, SEND=1) stays local.
- Single module. No sub-module is warranted; the pending buffer is one register plus a valid bit.
- Top level instantiates this block on r512's m/done outputs.

Test Plan:
- Basic stream: result word i = 32'h1000_0000+i, done pulse, out_ready held 1 → the following 16 cycles show m = 32'h1000_0000..32'h1000_000F in order. m_last=1 only with 32'h1000_000F. Then m_valid=0 and busy=0.
- Backpressure: out_ready low for 3 cycles while word 2 is presented → m stays 32'h1000_0002 with m_valid=1 for all 3 cycles. Word 3 follows after ready rises. Total of 16 transfers.
- Back-to-back: second result (words 32'h2000_0000+i) arrives with done at transfer 5 of the first → 32 consecutive transfers with no m_valid gap. The first m_last is followed immediately by 32'h2000_0000. overrun=0.
- Overrun: third done (words 32'h3000_0000+i) while the first is streaming and the second is pending → overrun=1 and stays 1. The 32'h3000_xxxx words never appear on m.
- Coincident events: done asserted on the same edge as the last transfer with pending empty → next cycle m=new word 0, m_valid=1, no idle cycle.
- Reset mid-stream: rst asserted between edges after word 7 → m_valid, m, busy, overrun go to 0 immediately without a clock edge. After release, a new done streams from word 0.
